// File: rtl/bus_master_arb_mux.sv
// Shared-bus master arbiter with registered active-low one-hot grants and
// a combinational master-to-slave mux driven from the registered owner.
module bus_master_arb_mux #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ARB_MODE  = 1,
  parameter int unsigned MAX_HOLD  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_req_,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS-1:0]          m_as_,
  input  logic [N_MASTERS-1:0]          m_rw,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wr_data,
  output logic [N_MASTERS-1:0]          m_grnt_,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_as_,
  output logic                          s_rw,
  output logic [DATA_W-1:0]             s_wr_data
);

  localparam int unsigned OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t               r_state, w_state_nxt;
  logic [OW-1:0]        r_owner, w_owner_nxt;
  logic [HW-1:0]        r_hold, w_hold_nxt;
  logic [OW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [N_MASTERS-1:0] r_grnt_, w_grnt_nxt;
  logic [N_MASTERS-1:0] w_cand;
  logic [OW-1:0]        w_idx;
  logic [OW-1:0]        w_winner;
  logic                 w_found;
  logic                 w_preempt;
  logic                 w_take;
  logic                 w_owner_valid;

  // Winner search; the current owner never competes (release or preemption).
  always_comb begin
    w_cand = ~m_req_;
    if (r_state == ST_OWNED) w_cand[r_owner] = 1'b0;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (ARB_MODE == 0) w_idx = OW'(k);
      else               w_idx = OW'((32'(r_rr_ptr) + k) % N_MASTERS);
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_preempt = (MAX_HOLD != 0) && (r_hold == HW'(MAX_HOLD - 1));

  // Next-state, next owner, hold counter and RR pointer.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_hold_nxt   = r_hold;
    w_rr_ptr_nxt = r_rr_ptr;
    w_take       = 1'b0;
    w_grnt_nxt   = '1;
    case (r_state)
      ST_IDLE: w_take = w_found;
      ST_OWNED: begin
        if (m_req_[r_owner]) begin
          w_take = w_found;
          if (!w_found) begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
          end
        end else if (w_preempt && w_found) begin
          w_take = 1'b1;
        end else if (r_hold != HW'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_take) begin
      w_state_nxt  = ST_OWNED;
      w_owner_nxt  = w_winner;
      w_hold_nxt   = '0;
      w_rr_ptr_nxt = (w_winner == OW'(N_MASTERS - 1)) ? '0 : w_winner + OW'(1);
    end
    if (w_state_nxt == ST_OWNED) w_grnt_nxt[w_owner_nxt] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_hold   <= '0;
      r_rr_ptr <= '0;
      r_grnt_  <= '1;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_hold   <= w_hold_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_grnt_  <= w_grnt_nxt;
    end
  end

  assign m_grnt_       = r_grnt_;
  assign w_owner_valid = (r_state == ST_OWNED);

  // Slave side follows the owner's live inputs; idle bus reads as a parked READ.
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (w_owner_valid) begin
      s_addr    = m_addr[32'(r_owner)*ADDR_W +: ADDR_W];
      s_as_     = m_as_[r_owner];
      s_rw      = m_rw[r_owner];
      s_wr_data = m_wr_data[32'(r_owner)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_bus_master_arb_mux.sv
// Bench for bus_master_arb_mux: three configurations share one stimulus and
// are checked against directed expectations and a per-instance reference model.
module tb_bus_master_arb_mux;

  localparam int NM = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int ND = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     req_n;
  logic [NM*AW-1:0]  m_addr;
  logic [NM-1:0]     as_n;
  logic [NM-1:0]     rw;
  logic [NM*DW-1:0]  wd;

  logic [NM-1:0]     grnt  [ND];
  logic [AW-1:0]     saddr [ND];
  logic              sas   [ND];
  logic              srw   [ND];
  logic [DW-1:0]     swd   [ND];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: round-robin unlimited, 1: fixed priority unlimited, 2: round-robin MAX_HOLD=4
  bus_master_arb_mux #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .MAX_HOLD(0)) dut_rr (
    .clk(clk), .reset(reset), .m_req_(req_n), .m_addr(m_addr), .m_as_(as_n), .m_rw(rw),
    .m_wr_data(wd), .m_grnt_(grnt[0]), .s_addr(saddr[0]), .s_as_(sas[0]), .s_rw(srw[0]),
    .s_wr_data(swd[0]));
  bus_master_arb_mux #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .MAX_HOLD(0)) dut_fp (
    .clk(clk), .reset(reset), .m_req_(req_n), .m_addr(m_addr), .m_as_(as_n), .m_rw(rw),
    .m_wr_data(wd), .m_grnt_(grnt[1]), .s_addr(saddr[1]), .s_as_(sas[1]), .s_rw(srw[1]),
    .s_wr_data(swd[1]));
  bus_master_arb_mux #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .MAX_HOLD(4)) dut_ph (
    .clk(clk), .reset(reset), .m_req_(req_n), .m_addr(m_addr), .m_as_(as_n), .m_rw(rw),
    .m_wr_data(wd), .m_grnt_(grnt[2]), .s_addr(saddr[2]), .s_as_(sas[2]), .s_rw(srw[2]),
    .s_wr_data(swd[2]));

  // Reference model: owner (-1 = none), cycles held, round-robin start point.
  typedef struct {
    int owner;
    int hold;
    int ptr;
  } mst_t;

  mst_t ms [ND];

  function automatic mst_t mstep(input mst_t s, input logic [NM-1:0] rq_n, input logic rst,
                                 input int mode, input int maxh);
    mst_t n;
    int   excl;
    int   win;
    int   idx;
    bit   others;
    n = s;
    excl = -1;
    win = -1;
    others = 1'b0;
    if (rst) begin
      n.owner = -1;
      n.hold  = 0;
      n.ptr   = 0;
      return n;
    end
    if (s.owner >= 0) begin
      for (int i = 0; i < NM; i++)
        if (i != s.owner && rq_n[i] == 1'b0) others = 1'b1;
      if (rq_n[s.owner] == 1'b0 && !(maxh > 0 && s.hold == maxh - 1 && others)) begin
        if (s.hold < maxh) n.hold = s.hold + 1;
        return n;
      end
      excl = s.owner;
    end
    for (int k = 0; k < NM; k++) begin
      idx = (mode == 1) ? (s.ptr + k) % NM : k;
      if (win < 0 && idx != excl && rq_n[idx] == 1'b0) win = idx;
    end
    n.hold = 0;
    if (win < 0) n.owner = -1;
    else begin
      n.owner = win;
      n.ptr   = (win + 1) % NM;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ms[0] = mstep(ms[0], req_n, reset, 1, 0);
    ms[1] = mstep(ms[1], req_n, reset, 0, 0);
    ms[2] = mstep(ms[2], req_n, reset, 1, 4);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_n = '1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_n = '1;
    as_n  = '1;
    rw    = '1;
    for (int i = 0; i < NM; i++) begin
      m_addr[i*AW +: AW] = 30'($urandom) | 30'h1;
      wd[i*DW +: DW]     = $urandom | 32'h1;
    end
    tick();
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++; if (grnt[d] !== 4'hF) begin errors++; $display("FAIL reset_grnt dut%0d got %b exp 1111", d, grnt[d]); end
      checks++; if (sas[d] !== 1'b1) begin errors++; $display("FAIL reset_as dut%0d got %b exp 1", d, sas[d]); end
      checks++; if (srw[d] !== 1'b1) begin errors++; $display("FAIL reset_rw dut%0d got %b exp 1", d, srw[d]); end
      checks++; if (saddr[d] !== '0) begin errors++; $display("FAIL reset_addr dut%0d got %h exp 0", d, saddr[d]); end
      checks++; if (swd[d] !== '0) begin errors++; $display("FAIL reset_wdata dut%0d got %h exp 0", d, swd[d]); end
    end
    reset = 1'b0;
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++; if (grnt[d] !== 4'hF) begin errors++; $display("FAIL idle_after_reset dut%0d got %b exp 1111", d, grnt[d]); end
    end
  endtask

  task automatic test_single_latency();
    m_addr[2*AW +: AW] = 30'h100;
    as_n  = 4'b1011;
    req_n = 4'b1011;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++; if (grnt[d] !== 4'hF) begin errors++; $display("FAIL latency_early dut%0d got %b exp 1111", d, grnt[d]); end
    end
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++; if (grnt[d] !== 4'b1011) begin errors++; $display("FAIL latency_grnt dut%0d got %b exp 1011", d, grnt[d]); end
      checks++; if (saddr[d] !== 30'h100) begin errors++; $display("FAIL latency_addr dut%0d got %h exp 100", d, saddr[d]); end
      checks++; if (sas[d] !== 1'b0) begin errors++; $display("FAIL latency_as dut%0d got %b exp 0", d, sas[d]); end
    end
    req_n = '1;
    as_n  = '1;
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++; if (grnt[d] !== 4'hF) begin errors++; $display("FAIL release_idle dut%0d got %b exp 1111", d, grnt[d]); end
    end
  endtask

  task automatic test_fixed_priority();
    req_n = 4'b0110;
    tick();
    checks++; if (grnt[1] !== 4'b1110) begin errors++; $display("FAIL fp_first got %b exp 1110", grnt[1]); end
    req_n = 4'b0111;
    tick();
    checks++; if (grnt[1] !== 4'b0111) begin errors++; $display("FAIL fp_handover got %b exp 0111", grnt[1]); end
    req_n = '1;
    tick();
    checks++; if (grnt[1] !== 4'hF) begin errors++; $display("FAIL fp_idle got %b exp 1111", grnt[1]); end
    req_n = 4'b0001;
    tick();
    checks++; if (grnt[1] !== 4'b1101) begin errors++; $display("FAIL fp_lowest got %b exp 1101", grnt[1]); end
    req_n = '1;
    tick();
  endtask

  task automatic test_round_robin();
    int         exp_own [10];
    logic [3:0] eg;
    exp_own = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    do_reset();
    req_n = '0;
    for (int s = 0; s < 10; s++) begin
      tick();
      eg = 4'hF;
      eg[exp_own[s]] = 1'b0;
      checks++; if (grnt[0] !== eg) begin errors++; $display("FAIL rr_order step%0d dut0 got %b exp %b", s, grnt[0], eg); end
      checks++; if (grnt[2] !== eg) begin errors++; $display("FAIL rr_order step%0d dut2 got %b exp %b", s, grnt[2], eg); end
      req_n = '0;
      if (s % 2 == 1) req_n[exp_own[s]] = 1'b1;
    end
    req_n = '1;
    tick();
  endtask

  task automatic test_preempt();
    logic [3:0] eg;
    do_reset();
    req_n = 4'b1101;
    for (int c = 1; c <= 12; c++) begin
      tick();
      eg = (((c - 1) / 4) % 2 == 0) ? 4'b1101 : 4'b0111;
      checks++; if (grnt[2] !== eg) begin errors++; $display("FAIL preempt cyc%0d got %b exp %b", c, grnt[2], eg); end
      checks++; if (grnt[0] !== 4'b1101) begin errors++; $display("FAIL no_limit_hold cyc%0d got %b exp 1101", c, grnt[0]); end
      if (c == 1) req_n[3] = 1'b0;
    end
    req_n = '1;
    tick();
    do_reset();
    req_n = 4'b1101;
    for (int c = 1; c <= 24; c++) begin
      tick();
      checks++; if (grnt[2] !== 4'b1101) begin errors++; $display("FAIL lone_owner cyc%0d got %b exp 1101", c, grnt[2]); end
    end
    req_n = '1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v;
    do_reset();
    v = $urandom;
    wd[DW-1:0] = v;
    as_n  = 4'b1110;
    rw    = 4'b1110;
    req_n = 4'b1110;
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++; if (grnt[d] !== 4'b1110) begin errors++; $display("FAIL mid_grant dut%0d got %b exp 1110", d, grnt[d]); end
      checks++; if (sas[d] !== 1'b0) begin errors++; $display("FAIL mid_as dut%0d got %b exp 0", d, sas[d]); end
      checks++; if (srw[d] !== 1'b0) begin errors++; $display("FAIL mid_rw dut%0d got %b exp 0", d, srw[d]); end
      checks++; if (swd[d] !== v) begin errors++; $display("FAIL mid_wdata dut%0d got %h exp %h", d, swd[d], v); end
    end
    reset = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++; if (grnt[d] !== 4'hF) begin errors++; $display("FAIL mid_reset_grnt dut%0d got %b exp 1111", d, grnt[d]); end
      checks++; if (sas[d] !== 1'b1) begin errors++; $display("FAIL mid_reset_as dut%0d got %b exp 1", d, sas[d]); end
    end
    reset = 1'b0;
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++; if (grnt[d] !== 4'b1110) begin errors++; $display("FAIL regrant dut%0d got %b exp 1110", d, grnt[d]); end
    end
    req_n = '1;
    as_n  = '1;
    rw    = '1;
    tick();
  endtask

  task automatic test_random();
    logic [3:0]    eg;
    logic [AW-1:0] ea;
    logic          eas;
    logic          erw;
    logic [DW-1:0] ewd;
    int            o;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 5) == 0) req_n[i] = ~req_n[i];
        m_addr[i*AW +: AW] = 30'($urandom);
        wd[i*DW +: DW]     = $urandom;
      end
      as_n  = 4'($urandom);
      rw    = 4'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
      for (int d = 0; d < ND; d++) begin
        o = ms[d].owner;
        eg = 4'hF; ea = '0; eas = 1'b1; erw = 1'b1; ewd = '0;
        if (o >= 0) begin
          eg[o] = 1'b0;
          ea  = m_addr[o*AW +: AW];
          eas = as_n[o];
          erw = rw[o];
          ewd = wd[o*DW +: DW];
        end
        checks++; if (grnt[d] !== eg) begin errors++; $display("FAIL rand_grnt n%0d dut%0d got %b exp %b", n, d, grnt[d], eg); end
        checks++; if (saddr[d] !== ea || sas[d] !== eas || srw[d] !== erw || swd[d] !== ewd) begin
          errors++;
          $display("FAIL rand_mux n%0d dut%0d got %h/%b/%b/%h exp %h/%b/%b/%h", n, d,
                   saddr[d], sas[d], srw[d], swd[d], ea, eas, erw, ewd);
        end
      end
    end
    reset = 1'b0;
    req_n = '1;
    tick();
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      ms[d].owner = -1;
      ms[d].hold  = 0;
      ms[d].ptr   = 0;
    end
    reset  = 1'b1;
    req_n  = '1;
    as_n   = '1;
    rw     = '1;
    m_addr = '0;
    wd     = '0;
    test_reset();
    test_single_latency();
    test_fixed_priority();
    test_round_robin();
    test_preempt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
